// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural register file.
// Default widths, derived register count, index type and the hardwired zero index.
package regfile_pkg;

  localparam int BIT_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_REGS       = 2 ** ADDR_WIDTH_DEF;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index decode, zero-register force and, when
// REGFILE_BYPASS_EN is defined, write-through bypass of the in-flight write.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [(2**ADDR_WIDTH)-1:0][BIT_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                     addr,
  input  logic                                      write_en,
  input  logic [ADDR_WIDTH-1:0]                     write_addr,
  input  logic [BIT_WIDTH-1:0]                      write_data,
  output logic [BIT_WIDTH-1:0]                      data
);

  always_comb begin
    data = regs[addr];
    if (addr == ADDR_WIDTH'(ZERO_REG)) begin
      data = '0;
    end
`ifdef REGFILE_BYPASS_EN
    // write_en is already qualified against index 0 by the top
    else if (write_en && (write_addr == addr)) begin
      data = write_data;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_ok;
  assign unused_ok = ^{write_en, write_addr, write_data};
`endif

endmodule

// File: rtl/register_file.sv
// Architectural register file: 2 combinational read ports, 1 synchronous write port,
// register 0 hardwired to zero. Optional write-through bypass: REGFILE_BYPASS_EN.
module register_file
  import regfile_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [BIT_WIDTH-1:0]  writeData,
  input  logic [ADDR_WIDTH-1:0] readAddr1,
  input  logic [ADDR_WIDTH-1:0] readAddr2,
  output logic [BIT_WIDTH-1:0]  readData1,
  output logic [BIT_WIDTH-1:0]  readData2
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [NREGS-1:0][BIT_WIDTH-1:0] regs;
  logic                            write_en;

  assign write_en = regWrite && (writeAddr != ADDR_WIDTH'(ZERO_REG));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[writeAddr] <= writeData;
    end
  end

  regfile_read_port #(
    .BIT_WIDTH (BIT_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port1 (
    .regs      (regs),
    .addr      (readAddr1),
    .write_en  (write_en),
    .write_addr(writeAddr),
    .write_data(writeData),
    .data      (readData1)
  );

  regfile_read_port #(
    .BIT_WIDTH (BIT_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port2 (
    .regs      (regs),
    .addr      (readAddr2),
    .write_en  (write_en),
    .write_addr(writeAddr),
    .write_data(writeData),
    .data      (readData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table, multi-cycle corner
// sequences and randomized traffic against an array-based reference model.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        resetN;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [4:0]  readAddr1;
  logic [4:0]  readAddr2;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int checks;
  int errors;

  logic [31:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [7];

  register_file dut (
    .clk      (clk),
    .resetN   (resetN),
    .regWrite (regWrite),
    .writeAddr(writeAddr),
    .writeData(writeData),
    .readAddr1(readAddr1),
    .readAddr2(readAddr2),
    .readData1(readData1),
    .readData2(readData2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic model_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    if (we && a != 5'd0) model[a] = d;
  endtask

  // what a read port should show before the edge, given the pending write
  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (BYP && we && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
    regWrite  = 1'b1;
    writeAddr = a;
    writeData = d;
    tick();
    model_write(1'b1, a, d);
    regWrite  = 1'b0;
  endtask

  initial begin
    logic [31:0] alu_b;
    logic        imm_sel;
    logic [31:0] imm;

    checks    = 0;
    errors    = 0;
    resetN    = 1'b0;
    regWrite  = 1'b0;
    writeAddr = '0;
    writeData = '0;
    readAddr1 = '0;
    readAddr2 = '0;
    model_clear();

    vecs[0] = '{1'b1, 5'd3,  32'd42,        5'd3,  5'd3,  32'd42,        32'd42};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF,  5'd0,  5'd3,  32'd0,         32'd42};
    vecs[2] = '{1'b0, 5'd7,  32'd9,         5'd7,  5'd7,  32'd0,         32'd0};
    vecs[3] = '{1'b1, 5'd4,  32'd2,         5'd4,  5'd3,  32'd2,         32'd42};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5,  5'd31, 5'd4,  32'hA5A5A5A5,  32'd2};
    vecs[5] = '{1'b0, 5'd31, 32'd0,         5'd31, 5'd0,  32'hA5A5A5A5,  32'd0};
    vecs[6] = '{1'b1, 5'd1,  32'd1,         5'd1,  5'd31, 32'd1,         32'hA5A5A5A5};

    repeat (2) @(posedge clk);
    #3;
    resetN = 1'b1;
    #1;

    // reset state of every entry
    for (int i = 0; i < 32; i++) begin
      readAddr1 = 5'(i);
      readAddr2 = 5'(31 - i);
      #1;
      check("reset_rd1", readData1, 32'd0);
      check("reset_rd2", readData2, 32'd0);
    end

    // asynchronous reset clears a loaded entry without a clock edge
    drive_write(5'd5, 32'hDEADBEEF);
    readAddr1 = 5'd5;
    #1;
    check("preload_r5", readData1, 32'hDEADBEEF);
    #2;
    resetN = 1'b0;
    #1;
    check("async_reset_r5", readData1, 32'd0);
    model_clear();
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("after_release_r5", readData1, 32'd0);

    // reset held across a write edge wins
    tick();
    regWrite  = 1'b1;
    writeAddr = 5'd6;
    writeData = 32'd77;
    #2;
    resetN = 1'b0;
    tick();
    regWrite  = 1'b0;
    resetN    = 1'b1;
    readAddr1 = 5'd6;
    #1;
    check("reset_wins_r6", readData1, 32'd0);

    // first write after release is accepted on the next edge
    drive_write(5'd6, 32'd123);
    #1;
    check("first_write_r6", readData1, 32'd123);

    // directed table, checked after each edge
    for (int i = 0; i < 7; i++) begin
      regWrite  = vecs[i].we;
      writeAddr = vecs[i].waddr;
      writeData = vecs[i].wdata;
      readAddr1 = vecs[i].raddr1;
      readAddr2 = vecs[i].raddr2;
      tick();
      model_write(vecs[i].we, vecs[i].waddr, vecs[i].wdata);
      check($sformatf("vec%0d_rd1", i), readData1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), readData2, vecs[i].exp2);
    end
    regWrite = 1'b0;

    // same-cycle read-after-write on reg 4 (holds 2)
    regWrite  = 1'b1;
    writeAddr = 5'd4;
    writeData = 32'd4;
    readAddr2 = 5'd4;
    readAddr1 = 5'd0;
    #1;
    check("raw_pre_edge", readData2, BYP ? 32'd4 : 32'd2);
    check("raw_rd1_zero", readData1, 32'd0);
    tick();
    model_write(1'b1, 5'd4, 32'd4);
    regWrite = 1'b0;
    #1;
    check("raw_post_edge", readData2, 32'd4);

    // write to reg 0 with bypass candidate on both ports stays 0
    regWrite  = 1'b1;
    writeAddr = 5'd0;
    writeData = 32'h12345678;
    readAddr1 = 5'd0;
    readAddr2 = 5'd0;
    #1;
    check("r0_pre_edge", readData1, 32'd0);
    tick();
    regWrite = 1'b0;
    check("r0_post_edge", readData2, 32'd0);

    // ALU-source mux fed from read port 2
    drive_write(5'd4, 32'd2);
    imm       = 32'd4;
    imm_sel   = 1'b0;
    readAddr2 = 5'd4;
    #1;
    alu_b = imm_sel ? imm : readData2;
    check("alu_src_sel0", alu_b, 32'd2);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [4:0]  wa, r1, r2;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, (n % 2 == 0) ? 7 : 31));
      wd = $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      regWrite  = we;
      writeAddr = wa;
      writeData = wd;
      readAddr1 = r1;
      readAddr2 = r2;
      #1;
      check("rand_rd1", readData1, model_read(r1, we, wa, wd));
      check("rand_rd2", readData2, model_read(r2, we, wa, wd));
      tick();
      model_write(we, wa, wd);
    end
    regWrite = 1'b0;

    // full sweep of stored state
    for (int i = 0; i < 32; i++) begin
      readAddr1 = 5'(i);
      readAddr2 = 5'(i);
      #1;
      check("sweep_rd1", readData1, (i == 0) ? 32'd0 : model[i]);
      check("sweep_rd2", readData2, (i == 0) ? 32'd0 : model[i]);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
